// File: rtl/sqrt_request_driver.sv
// rtl/sqrt_request_driver.sv - table-driven St/Done initiator for square_root_unit; optional SQRT_DRV_CHECK_EN result self-check
module sqrt_request_driver #(
    parameter int NUM_VECTORS = 16,
    parameter int IDX_W       = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             WrEn,
    input  logic [IDX_W-1:0] WrAddr,
    input  logic [7:0]       WrData,
    input  logic             Go,
    output logic             St,
    output logic [7:0]       N,
    input  logic             Done,
    input  logic [3:0]       Sqrt,
    output logic             ResValid,
    output logic [IDX_W-1:0] ResIdx,
    output logic [7:0]       ResN,
    output logic [3:0]       ResSqrt,
    output logic             ResErr,
    output logic [7:0]       ErrCount,
    output logic             Busy,
    output logic             SweepDone,
    output logic             TimedOut
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_REQ, S_RELEASE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VECTORS - 1);
    localparam logic [7:0]       TIMEOUT_C = 8'(TIMEOUT);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       n_q, n_d;
    logic             st_q, st_d;
    logic             busy_q, busy_d;
    logic             timed_out_q, timed_out_d;
    logic [7:0]       timer_q, timer_d;
    logic             res_valid_q, res_valid_d;
    logic             sweep_done_q, sweep_done_d;
    logic [IDX_W-1:0] res_idx_q, res_idx_d;
    logic [7:0]       res_n_q, res_n_d;
    logic [3:0]       res_sqrt_q, res_sqrt_d;
    logic [7:0]       timer_inc;
    logic [IDX_W-1:0] idx_next;
    logic             go_accept;
    logic             capture;

    // Operand table has no reset so the host's load survives a mid-sweep Reset.
    logic [7:0] tbl_q [NUM_VECTORS];

    always_ff @(posedge Clock) begin
        if (state_q == S_IDLE && WrEn) begin
            tbl_q[WrAddr] <= WrData;
        end
    end

    assign go_accept = (state_q == S_IDLE) && Go && !WrEn;
    assign capture   = (state_q == S_REQ) && Done;
    assign timer_inc = (timer_q == TIMEOUT_C) ? timer_q : timer_q + 8'd1;
    assign idx_next  = idx_q + IDX_W'(1);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        n_d          = n_q;
        st_d         = st_q;
        busy_d       = busy_q;
        timed_out_d  = timed_out_q;
        timer_d      = timer_q;
        res_valid_d  = 1'b0;
        sweep_done_d = 1'b0;
        res_idx_d    = res_idx_q;
        res_n_d      = res_n_q;
        res_sqrt_d   = res_sqrt_q;
        case (state_q)
            S_IDLE: begin
                if (go_accept) begin
                    idx_d       = '0;
                    n_d         = tbl_q[0];
                    busy_d      = 1'b1;
                    timed_out_d = 1'b0;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                st_d    = 1'b1;
                timer_d = 8'd0;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (Done) begin
                    st_d        = 1'b0;
                    res_valid_d = 1'b1;
                    res_idx_d   = idx_q;
                    res_n_d     = n_q;
                    res_sqrt_d  = Sqrt;
                    timer_d     = 8'd0;
                    state_d     = S_RELEASE;
                end else if (timer_inc == TIMEOUT_C) begin
                    st_d        = 1'b0;
                    busy_d      = 1'b0;
                    timed_out_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_RELEASE: begin
                // Holding here until Done drops is what keeps one result per request.
                if (!Done) begin
                    if (idx_q == LAST_IDX) begin
                        busy_d       = 1'b0;
                        sweep_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        idx_d   = idx_next;
                        n_d     = tbl_q[idx_next];
                        state_d = S_SETUP;
                    end
                end else if (timer_inc == TIMEOUT_C) begin
                    st_d        = 1'b0;
                    busy_d      = 1'b0;
                    timed_out_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            n_q          <= '0;
            st_q         <= 1'b0;
            busy_q       <= 1'b0;
            timed_out_q  <= 1'b0;
            timer_q      <= '0;
            res_valid_q  <= 1'b0;
            sweep_done_q <= 1'b0;
            res_idx_q    <= '0;
            res_n_q      <= '0;
            res_sqrt_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            st_q         <= st_d;
            busy_q       <= busy_d;
            timed_out_q  <= timed_out_d;
            timer_q      <= timer_d;
            res_valid_q  <= res_valid_d;
            sweep_done_q <= sweep_done_d;
            res_idx_q    <= res_idx_d;
            res_n_q      <= res_n_d;
            res_sqrt_q   <= res_sqrt_d;
        end
    end

`ifdef SQRT_DRV_CHECK_EN
    logic [9:0] sq_lo, sq_hi;
    logic       check_fail;
    logic       res_err_q, res_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    // 10 bits hold (15+1)^2 = 256 without wrapping.
    always_comb begin
        sq_lo      = {6'd0, Sqrt} * {6'd0, Sqrt};
        sq_hi      = ({6'd0, Sqrt} + 10'd1) * ({6'd0, Sqrt} + 10'd1);
        check_fail = !((sq_lo <= {2'b00, n_q}) && (sq_hi > {2'b00, n_q}));
        res_err_d  = res_err_q;
        err_cnt_d  = err_cnt_q;
        if (go_accept) begin
            err_cnt_d = 8'd0;
        end
        if (capture) begin
            res_err_d = check_fail;
            if (check_fail && err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            res_err_q <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            res_err_q <= res_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ResErr   = res_err_q;
    assign ErrCount = err_cnt_q;
`else
    assign ResErr   = 1'b0;
    assign ErrCount = 8'd0;
`endif

    assign St        = st_q;
    assign N         = n_q;
    assign Busy      = busy_q;
    assign TimedOut  = timed_out_q;
    assign ResValid  = res_valid_q;
    assign SweepDone = sweep_done_q;
    assign ResIdx    = res_idx_q;
    assign ResN      = res_n_q;
    assign ResSqrt   = res_sqrt_q;

endmodule

// File: tb/tb_sqrt_request_driver.sv
// tb/tb_sqrt_request_driver.sv - directed self-checking bench for sqrt_request_driver
module tb_sqrt_request_driver;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       WrEn;
    logic [3:0] WrAddr;
    logic [7:0] WrData;
    logic       Go;
    logic       St;
    logic [7:0] N;
    logic       Done;
    logic [3:0] Sqrt;
    logic       ResValid;
    logic [3:0] ResIdx;
    logic [7:0] ResN;
    logic [3:0] ResSqrt;
    logic       ResErr;
    logic [7:0] ErrCount;
    logic       Busy;
    logic       SweepDone;
    logic       TimedOut;

    sqrt_request_driver #(.NUM_VECTORS(16), .IDX_W(4), .TIMEOUT(20)) dut (
        .Clock(Clock), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .Go(Go), .St(St), .N(N), .Done(Done), .Sqrt(Sqrt),
        .ResValid(ResValid), .ResIdx(ResIdx), .ResN(ResN), .ResSqrt(ResSqrt),
        .ResErr(ResErr), .ErrCount(ErrCount), .Busy(Busy), .SweepDone(SweepDone),
        .TimedOut(TimedOut)
    );

    always #5 Clock = ~Clock;

`ifdef SQRT_DRV_CHECK_EN
    localparam logic CHECK_ON = 1'b1;
`else
    localparam logic CHECK_ON = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] tbl_v    [16];
    logic [3:0] exp_root [16];

    // Responder controls, written only by the stimulus block.
    logic never_mode = 1'b0;
    logic bad_mode = 1'b0;
    int   hold_cycles = 0;

    // Results captured by the monitor.
    logic [3:0] got_idx  [512];
    logic [7:0] got_n    [512];
    logic [3:0] got_sqrt [512];
    logic       got_err  [512];
    int res_count = 0;
    int sweep_count = 0;

    function automatic logic [3:0] isqrt(input logic [7:0] v);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(v)) r++;
        return 4'(r);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic go_pulse();
        @(negedge Clock);
        Go = 1'b1;
        @(negedge Clock);
        Go = 1'b0;
    endtask

    task automatic wait_sweep();
        int  n;
        logic prev_busy;
        prev_busy = Busy;
        for (n = 0; n < 3000; n++) begin
            tick();
            if (SweepDone) break;
            prev_busy = Busy;
        end
        if (n >= 3000) check("sweep_timeout", 64'd0, 64'd1);
        else check("sweep_busy_fall", {62'd0, prev_busy, Busy}, 64'b10);
    endtask

    task automatic check_results(input int base);
        check("res_count", 64'(res_count - base), 64'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("res[%0d]", i),
                  {48'd0, got_idx[base+i], got_n[base+i], got_sqrt[base+i]},
                  {48'd0, 4'(i), tbl_v[i], exp_root[i]});
        end
    endtask

    // Responder: Done rises 5 cycles after St, falls hold_cycles after St drops.
    initial begin
        int rcnt = 0;
        int hcnt = 0;
        Done = 1'b0;
        Sqrt = 4'd0;
        forever begin
            @(negedge Clock);
            if (Reset || never_mode) begin
                Done = 1'b0;
                rcnt = 0;
                hcnt = 0;
            end else if (!Done) begin
                if (St) begin
                    rcnt++;
                    if (rcnt >= 5) begin
                        Done = 1'b1;
                        Sqrt = (bad_mode && N == 8'h10) ? 4'd5 : isqrt(N);
                        rcnt = 0;
                    end
                end else begin
                    rcnt = 0;
                end
            end else if (!St) begin
                hcnt++;
                if (hcnt > hold_cycles) begin
                    Done = 1'b0;
                    hcnt = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clock);
            if (ResValid && res_count < 512) begin
                got_idx[res_count]  = ResIdx;
                got_n[res_count]    = ResN;
                got_sqrt[res_count] = ResSqrt;
                got_err[res_count]  = ResErr;
                res_count++;
            end
            if (SweepDone) sweep_count++;
        end
    end

    initial begin
        int base;
        int sbase;
        int errs;
        int n;
        int st_bad;
        int dhigh;
        logic st_at_low;

        tbl_v = '{8'h00, 8'h01, 8'h04, 8'h0F, 8'h10, 8'h51, 8'h90, 8'hFF,
                  8'h02, 8'h08, 8'h19, 8'h24, 8'h31, 8'h63, 8'hC8, 8'hE1};
        exp_root = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'hC, 4'hF,
                     4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h9, 4'hE, 4'hF};
        Reset = 1'b1; WrEn = 1'b0; WrAddr = 4'd0; WrData = 8'd0; Go = 1'b0;
        #12;
        check("reset_outputs",
              {St, N, ResValid, ResIdx, ResN, ResSqrt, ResErr, ErrCount, Busy, SweepDone, TimedOut},
              64'd0);
        @(negedge Clock);
        Reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge Clock);
            WrEn = 1'b1; WrAddr = 4'(i); WrData = tbl_v[i];
        end
        @(negedge Clock);
        WrEn = 1'b0;

        // Full sweep with first-request timing.
        base = res_count; sbase = sweep_count;
        @(negedge Clock);
        Go = 1'b1;
        tick();
        check("go_busy_st", {62'd0, Busy, St}, 64'b10);
        @(negedge Clock);
        Go = 1'b0;
        tick();
        check("go_st_rise", {63'd0, St}, 64'd1);
        wait_sweep();
        @(negedge Clock);
        check_results(base);
        check("sweep1_count", 64'(sweep_count - sbase), 64'd1);
        check("sweep1_errcount", {56'd0, ErrCount}, 64'd0);

        // Wrong root for N=0x10.
        bad_mode = 1'b1;
        base = res_count;
        go_pulse();
        wait_sweep();
        @(negedge Clock);
        bad_mode = 1'b0;
        errs = 0;
        for (int i = 0; i < 16; i++) errs += int'(got_err[base+i]);
        check("bad_err_idx4", {63'd0, got_err[base+4]}, {63'd0, CHECK_ON});
        check("bad_err_total", 64'(errs), CHECK_ON ? 64'd1 : 64'd0);
        check("bad_errcount", {56'd0, ErrCount}, CHECK_ON ? 64'd1 : 64'd0);

        // Done held high after St drops.
        hold_cycles = 10;
        base = res_count; sbase = sweep_count;
        go_pulse();
        for (n = 0; n < 100; n++) begin
            tick();
            if (ResValid) break;
        end
        check("hold_first_result", {63'd0, ResValid}, 64'd1);
        st_bad = 0; dhigh = 0;
        for (n = 0; n < 100; n++) begin
            if (!Done) break;
            if (St) st_bad++;
            dhigh++;
            tick();
        end
        st_at_low = St;
        check("hold_st_low_while_done", 64'(st_bad), 64'd0);
        check("hold_done_long", {63'd0, dhigh >= 10}, 64'd1);
        check("hold_st_at_done_low", {63'd0, st_at_low}, 64'd0);
        tick();
        check("hold_st_rise", {63'd0, St}, 64'd1);
        wait_sweep();
        @(negedge Clock);
        hold_cycles = 0;
        check("hold_res_count", 64'(res_count - base), 64'd16);
        check("hold_sweep_count", 64'(sweep_count - sbase), 64'd1);

        // Responder never answers.
        never_mode = 1'b1;
        sbase = sweep_count;
        go_pulse();
        for (n = 0; n < 50; n++) begin
            tick();
            if (St) break;
        end
        repeat (19) tick();
        check("to_still_waiting", {62'd0, Busy, St}, 64'b11);
        tick();
        check("to_abort", {61'd0, St, Busy, TimedOut}, 64'b001);
        repeat (3) tick();
        check("to_no_sweepdone", 64'(sweep_count - sbase), 64'd0);
        never_mode = 1'b0;
        go_pulse();
        tick();
        check("to_cleared_by_go", {62'd0, TimedOut, Busy}, 64'b01);
        wait_sweep();

        // Reset mid-sweep at ResIdx 7.
        go_pulse();
        for (n = 0; n < 500; n++) begin
            tick();
            if (ResValid && ResIdx == 4'd7) break;
        end
        check("rst_reached_idx7", {63'd0, ResValid}, 64'd1);
        #1 Reset = 1'b1;
        #1;
        check("rst_async_outputs",
              {St, N, ResValid, ResIdx, ResN, ResSqrt, ResErr, ErrCount, Busy, SweepDone, TimedOut},
              64'd0);
        @(negedge Clock);
        Reset = 1'b0;
        base = res_count;
        go_pulse();
        wait_sweep();
        @(negedge Clock);
        check_results(base);

        // Writes during Busy are dropped; Go with WrEn in IDLE writes only.
        base = res_count;
        go_pulse();
        @(negedge Clock);
        WrEn = 1'b1; WrAddr = 4'd3; WrData = 8'hAA;
        @(negedge Clock);
        WrEn = 1'b0;
        wait_sweep();
        @(negedge Clock);
        check("busy_write_ignored", {56'd0, got_n[base+3]}, 64'h0F);
        @(negedge Clock);
        WrEn = 1'b1; Go = 1'b1; WrAddr = 4'd3; WrData = 8'hAA;
        @(negedge Clock);
        WrEn = 1'b0; Go = 1'b0;
        repeat (3) tick();
        check("go_with_wren_no_start", {62'd0, Busy, St}, 64'd0);
        tbl_v[3] = 8'hAA;
        exp_root[3] = 4'hD;
        base = res_count;
        go_pulse();
        wait_sweep();
        @(negedge Clock);
        check_results(base);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
